// File: rtl/masking_pkg.sv
// rtl/masking_pkg.sv - shared helpers for Boolean-masked gadgets
//
// Purpose: index arithmetic for pairwise randomness and a share-slice macro
//          used by the masked AND gadget and its relatives.
// Contents:
//   rand_idx(i, j, shares) - linear index of the random word for pair i<j
//   rand_words(order)      - number of random words an order-d ISW gadget needs
//   `MSK_SHARE(vec, i, w)  - share i of a flat share vector with w bits per share

`define MSK_SHARE(vec, i, w) vec[(i)*(w) +: (w)]

package masking_pkg;

   // Row-major enumeration of the strict upper triangle: (0,1),(0,2),..,(1,2),..
   function automatic int rand_idx(input int i, input int j, input int shares);
      return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   function automatic int rand_words(input int order);
      return (order * (order + 1)) / 2;
   endfunction

endpackage

// File: rtl/and_isw_pipe_ctrl.sv
// rtl/and_isw_pipe_ctrl.sv - two-entry valid/ready control for the ISW pipe
//
// Purpose: tracks occupancy of the two gadget stages and produces the load
//          enables for their data registers.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   upstream item offered
//   in_ready   stage 1 can accept
//   out_valid  stage 2 holds a result
//   out_ready  downstream accepts the result
//   s1_load    stage 1 data registers capture this cycle
//   s2_load    stage 2 data registers capture this cycle

module and_isw_pipe_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   output logic out_valid,
   input  logic out_ready,
   output logic s1_load,
   output logic s2_load
);

   logic v1_q, v1_d;
   logic v2_q, v2_d;
   logic s1_adv, s2_adv;

   always_comb begin
      s2_adv  = !v2_q || out_ready;
      s1_adv  = !v1_q || s2_adv;
      s1_load = in_valid && s1_adv;
      s2_load = v1_q && s2_adv;
      // A stage that advances takes whatever the previous stage offers,
      // which is how bubbles propagate as cleared valid bits.
      v1_d = s1_adv ? in_valid : v1_q;
      v2_d = s2_adv ? v1_q : v2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = v2_q;

endmodule

// File: rtl/and_isw_pipe.sv
// rtl/and_isw_pipe.sv - registered ISW masked AND gadget, any order, W lanes
//
// Purpose: c with XOR(c) = XOR(a) & XOR(b); stage 1 registers every cross
//          product separately, stage 2 compresses them in fixed ISW order.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    a, b, r offered;  in_ready  stage 1 can accept
//   port_a/b    SHARES*W, share i at [i*W +: W]
//   port_r      RAND*W (1 bit when RAND=0), pair word k(i,j) at [k*W +: W]
//   out_valid   port_c valid;  out_ready  consumer accepts port_c
//   port_c      SHARES*W product shares

module and_isw_pipe
   import masking_pkg::*;
#(
   parameter  int ORDER  = 1,
   parameter  int W      = 1,
   localparam int SHARES = ORDER + 1,
   localparam int RAND   = rand_words(ORDER),
   localparam int RW     = (RAND > 0) ? RAND * W : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SHARES*W-1:0] port_a,
   input  logic [SHARES*W-1:0] port_b,
   input  logic [RW-1:0]       port_r,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SHARES*W-1:0] port_c
);

   localparam int NP = (RAND > 0) ? RAND : 1;

   logic s1_load, s2_load;

   logic [SHARES-1:0][W-1:0] x_new, x_d, x_q;
   logic [NP-1:0][W-1:0]     r_new, r_d, r_q;
   logic [NP-1:0][W-1:0]     t_new, t_d, t_q;
   logic [NP-1:0][W-1:0]     u_new, u_d, u_q;
   logic [SHARES-1:0][W-1:0] c_new, c_d, c_q;

   and_isw_pipe_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s1_load   (s1_load),
      .s2_load   (s2_load)
   );

   // Stage 1 terms: each product lands in its own register so no glitch can
   // combine two shares of the same operand before the cut.
   for (genvar i = 0; i < SHARES; i++) begin : g_s1
      assign x_new[i] = `MSK_SHARE(port_a, i, W) & `MSK_SHARE(port_b, i, W);
      for (genvar j = i + 1; j < SHARES; j++) begin : g_pair
         localparam int K = rand_idx(i, j, SHARES);
         assign r_new[K] = `MSK_SHARE(port_r, K, W);
         assign t_new[K] = `MSK_SHARE(port_r, K, W)
                         ^ (`MSK_SHARE(port_a, i, W) & `MSK_SHARE(port_b, j, W));
         assign u_new[K] = `MSK_SHARE(port_a, j, W) & `MSK_SHARE(port_b, i, W);
      end
   end

   if (RAND == 0) begin : g_no_rand
      assign r_new = '0;
      assign t_new = '0;
      assign u_new = '0;
   end

   // Stage 2 compression as an explicit left-to-right chain: first the r terms
   // for j>i, then (t ^ u) for j<i with t entering before u.
   for (genvar i = 0; i < SHARES; i++) begin : g_s2
      logic [SHARES-1:0][W-1:0] chain;
      assign chain[0] = x_q[i];
      for (genvar n = 0; n < SHARES - 1; n++) begin : g_term
         if (n < SHARES - 1 - i) begin : g_r
            localparam int K = rand_idx(i, i + 1 + n, SHARES);
            assign chain[n+1] = chain[n] ^ r_q[K];
         end else begin : g_tu
            localparam int K = rand_idx(n - (SHARES - 1 - i), i, SHARES);
            assign chain[n+1] = (chain[n] ^ t_q[K]) ^ u_q[K];
         end
      end
      assign c_new[i] = chain[SHARES-1];
   end

   always_comb begin
      x_d = x_q;
      r_d = r_q;
      t_d = t_q;
      u_d = u_q;
      c_d = c_q;
      if (s1_load) begin
         x_d = x_new;
         r_d = r_new;
         t_d = t_new;
         u_d = u_new;
      end
      if (s2_load) begin
         c_d = c_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         r_q <= '0;
         t_q <= '0;
         u_q <= '0;
         c_q <= '0;
      end else begin
         x_q <= x_d;
         r_q <= r_d;
         t_q <= t_d;
         u_q <= u_d;
         c_q <= c_d;
      end
   end

   assign port_c = c_q;

endmodule

// File: tb/tb_and_isw_pipe.sv
// tb/tb_and_isw_pipe.sv - directed bench for the registered ISW AND gadget

module tb_and_isw_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // d=1, W=1
   logic       iv1, ir1, ov1, or1;
   logic [1:0] a1, b1, c1;
   logic [0:0] r1;
   // d=2, W=8
   logic        iv2, ir2, ov2, or2;
   logic [23:0] a2, b2, c2, r2;
   // d=3, W=4
   logic        iv3, ir3, ov3, or3;
   logic [15:0] a3, b3, c3;
   logic [23:0] r3;

   and_isw_pipe #(.ORDER(1), .W(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .port_a(a1), .port_b(b1),
      .port_r(r1), .out_valid(ov1), .out_ready(or1), .port_c(c1));
   and_isw_pipe #(.ORDER(2), .W(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .port_a(a2), .port_b(b2),
      .port_r(r2), .out_valid(ov2), .out_ready(or2), .port_c(c2));
   and_isw_pipe #(.ORDER(3), .W(4)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .port_a(a3), .port_b(b3),
      .port_r(r3), .out_valid(ov3), .out_ready(or3), .port_c(c3));

   logic [31:0] exp_q [$];
   logic [31:0] prod_q [$];

   // Golden ISW: c_i = a_i b_i ^ sum_{j>i} r_ij ^ sum_{j<i} (r_ji ^ a_j b_i ^ a_i b_j)
   function automatic logic [31:0] isw_model(input int sh, input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] r);
      logic [31:0] c, m, acc, ai, bi, aj, bj;
      int kk [4][4];
      int k;
      m = (32'd1 << w) - 32'd1;
      k = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            kk[i][j] = 0;
      for (int i = 0; i < sh; i++)
         for (int j = i + 1; j < sh; j++) begin
            kk[i][j] = k;
            k++;
         end
      c = '0;
      for (int i = 0; i < sh; i++) begin
         ai  = (a >> (i * w)) & m;
         bi  = (b >> (i * w)) & m;
         acc = ai & bi;
         for (int j = 0; j < sh; j++) begin
            aj = (a >> (j * w)) & m;
            bj = (b >> (j * w)) & m;
            if (j > i)
               acc = acc ^ ((r >> (kk[i][j] * w)) & m);
            else if (j < i)
               acc = acc ^ ((r >> (kk[j][i] * w)) & m) ^ (aj & bi) ^ (ai & bj);
         end
         c = c | ((acc & m) << (i * w));
      end
      return c;
   endfunction

   function automatic logic [31:0] unmask(input int sh, input int w, input logic [31:0] v);
      logic [31:0] m, s;
      m = (32'd1 << w) - 32'd1;
      s = '0;
      for (int i = 0; i < sh; i++)
         s = s ^ ((v >> (i * w)) & m);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv1 = 0; or1 = 1; a1 = '0; b1 = '0; r1 = '0;
      iv2 = 0; or2 = 1; a2 = '0; b2 = '0; r2 = '0;
      iv3 = 0; or3 = 1; a3 = '0; b3 = '0; r3 = '0;
      tick();
      tick();
      n_total++;
      if ({ov1, ov2, ov3} !== 3'b000) $display("FAIL reset_out_valid got=%b want=000", {ov1, ov2, ov3});
      else n_pass++;
      n_total++;
      if ({c1, c2, c3} !== 42'd0) $display("FAIL reset_port_c got=%h want=0", {c1, c2, c3});
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({ir1, ir2, ir3} !== 3'b111) $display("FAIL reset_in_ready got=%b want=111", {ir1, ir2, ir3});
      else n_pass++;
   endtask

   task automatic test_latency();
      iv1 = 1; a1 = 2'b01; b1 = 2'b01; r1 = 1'b1; or1 = 1;
      #1;
      n_total++;
      if (ir1 !== 1'b1) $display("FAIL lat_accept in_ready got=%b want=1", ir1);
      else n_pass++;
      tick();
      iv1 = 0;
      n_total++;
      if (ov1 !== 1'b0) $display("FAIL lat_cycle1 out_valid got=%b want=0", ov1);
      else n_pass++;
      tick();
      n_total++;
      if (ov1 !== 1'b1 || c1 !== 2'b10) $display("FAIL lat_cycle2 got v=%b c=%b want v=1 c=10", ov1, c1);
      else n_pass++;
      tick();
      n_total++;
      if (ov1 !== 1'b0) $display("FAIL lat_cycle3 out_valid got=%b want=0", ov1);
      else n_pass++;
   endtask

   task automatic test_exhaustive();
      int n_out;
      logic [31:0] e, p;
      n_out = 0;
      or1 = 1;
      for (int v = 0; v < 34; v++) begin
         if (v < 32) begin
            iv1 = 1; a1 = 2'(v & 3); b1 = 2'((v >> 2) & 3); r1 = 1'((v >> 4) & 1);
         end else begin
            iv1 = 0;
         end
         #1;
         if (ov1) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL exh_spurious got c=%b want no output", c1);
            end else begin
               e = exp_q.pop_front();
               p = prod_q.pop_front();
               n_total++;
               if (32'(c1) !== e) $display("FAIL exh_shares got=%b want=%b", c1, e[1:0]);
               else n_pass++;
               n_total++;
               if (unmask(2, 1, 32'(c1)) !== p) $display("FAIL exh_unmasked got=%0d want=%0d", unmask(2, 1, 32'(c1)), p);
               else n_pass++;
            end
         end
         if (iv1 && ir1) begin
            exp_q.push_back(isw_model(2, 1, 32'(a1), 32'(b1), 32'(r1)));
            prod_q.push_back(32'((a1[0] ^ a1[1]) & (b1[0] ^ b1[1])));
         end
         tick();
      end
      n_total++;
      if (n_out !== 32) $display("FAIL exh_count got=%0d want=32", n_out);
      else n_pass++;
      exp_q.delete();
      prod_q.delete();
   endtask

   task automatic test_back_to_back();
      int n_out, n_acc, n_bad;
      logic [31:0] e, p, ua, ub;
      n_out = 0; n_acc = 0; n_bad = 0;
      or2 = 1;
      for (int cyc = 0; cyc < 1002; cyc++) begin
         if (cyc < 1000) begin
            iv2 = 1; a2 = 24'($urandom); b2 = 24'($urandom); r2 = 24'($urandom);
         end else begin
            iv2 = 0;
         end
         #1;
         if (ov2) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_bad++;
            end else begin
               e = exp_q.pop_front();
               p = prod_q.pop_front();
               if (32'(c2) !== e || unmask(3, 8, 32'(c2)) !== p) begin
                  n_bad++;
                  if (n_bad < 4) $display("FAIL b2b_item got=%h want=%h prod_want=%h", c2, e[23:0], p[7:0]);
               end
            end
         end
         if (iv2 && ir2) begin
            n_acc++;
            ua = 32'(a2[7:0] ^ a2[15:8] ^ a2[23:16]);
            ub = 32'(b2[7:0] ^ b2[15:8] ^ b2[23:16]);
            exp_q.push_back(isw_model(3, 8, 32'(a2), 32'(b2), 32'(r2)));
            prod_q.push_back(ua & ub);
         end
         tick();
      end
      n_total++;
      if (n_bad !== 0) $display("FAIL b2b_items bad=%0d want=0", n_bad);
      else n_pass++;
      n_total++;
      if (n_acc !== 1000) $display("FAIL b2b_accepts got=%0d want=1000", n_acc);
      else n_pass++;
      // Outputs can only appear in the 1000 slots from cycle 2 to 1001, so a
      // full count means one result per cycle.
      n_total++;
      if (n_out !== 1000) $display("FAIL b2b_outputs got=%0d want=1000", n_out);
      else n_pass++;
      exp_q.delete();
      prod_q.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] ea, eb;
      int n_out, n_bad;
      or2 = 0;
      iv2 = 1; a2 = 24'h3C5A96; b2 = 24'hF00FFF; r2 = 24'h123456;
      ea = isw_model(3, 8, 32'(a2), 32'(b2), 32'(r2));
      #1;
      n_total++;
      if (ir2 !== 1'b1) $display("FAIL bp_accept0 in_ready got=%b want=1", ir2);
      else n_pass++;
      tick();
      a2 = 24'hA1B2C3; b2 = 24'h0F1E2D; r2 = 24'h998877;
      eb = isw_model(3, 8, 32'(a2), 32'(b2), 32'(r2));
      #1;
      n_total++;
      if (ir2 !== 1'b1) $display("FAIL bp_accept1 in_ready got=%b want=1", ir2);
      else n_pass++;
      tick();
      a2 = 24'hFFFFFF; b2 = 24'hFFFFFF; r2 = 24'h000000;
      n_bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (ir2 !== 1'b0 || ov2 !== 1'b1 || 32'(c2) !== ea) n_bad++;
         tick();
      end
      n_total++;
      if (n_bad !== 0) $display("FAIL bp_hold bad_cycles=%0d want=0 (last c=%h want=%h)", n_bad, c2, ea[23:0]);
      else n_pass++;
      iv2 = 0; or2 = 1;
      n_out = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (ov2) begin
            n_out++;
            n_total++;
            if (n_out == 1 && 32'(c2) !== ea) $display("FAIL bp_drain_first got=%h want=%h", c2, ea[23:0]);
            else if (n_out == 2 && 32'(c2) !== eb) $display("FAIL bp_drain_second got=%h want=%h", c2, eb[23:0]);
            else if (n_out > 2) $display("FAIL bp_drain_extra got=%h want none", c2);
            else n_pass++;
         end
         tick();
      end
      n_total++;
      if (n_out !== 2) $display("FAIL bp_drain_count got=%0d want=2", n_out);
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      int seen;
      or1 = 1;
      iv1 = 1; a1 = 2'b01; b1 = 2'b01; r1 = 1'b1;
      tick();
      iv1 = 0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (ov1 !== 1'b0 || c1 !== 2'b00) $display("FAIL rst_async got v=%b c=%b want v=0 c=00", ov1, c1);
      else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (ir1 !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", ir1);
      else n_pass++;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ov1) seen++;
      end
      n_total++;
      if (seen !== 0) $display("FAIL rst_discard outputs=%0d want=0", seen);
      else n_pass++;
      iv1 = 1; a1 = 2'b11; b1 = 2'b11; r1 = 1'b0;
      tick();
      iv1 = 0;
      n_total++;
      if (ov1 !== 1'b0) $display("FAIL rst_post_lat1 out_valid got=%b want=0", ov1);
      else n_pass++;
      tick();
      n_total++;
      if (ov1 !== 1'b1 || c1 !== 2'b11) $display("FAIL rst_post_lat2 got v=%b c=%b want v=1 c=11", ov1, c1);
      else n_pass++;
      tick();
   endtask

   task automatic test_alternating();
      int n_acc, n_out, n_bad;
      logic [31:0] e;
      n_acc = 0; n_out = 0; n_bad = 0;
      for (int cyc = 0; cyc < 230; cyc++) begin
         iv3 = (cyc < 200) && ((cyc % 2) == 0 || (cyc % 7) == 3);
         or3 = (cyc >= 200) || ((cyc % 3) != 0);
         a3 = 16'($urandom); b3 = 16'($urandom); r3 = 24'($urandom);
         #1;
         if (ov3 && or3) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_bad++;
            end else begin
               e = exp_q.pop_front();
               if (32'(c3) !== e || unmask(4, 4, 32'(c3)) !== (unmask(4, 4, e))) n_bad++;
               if (32'(c3) !== e && n_bad < 4) $display("FAIL alt_item got=%h want=%h", c3, e[15:0]);
            end
         end
         if (iv3 && ir3) begin
            n_acc++;
            e = isw_model(4, 4, 32'(a3), 32'(b3), 32'(r3));
            exp_q.push_back(e);
            prod_q.push_back(unmask(4, 4, 32'(a3)) & unmask(4, 4, 32'(b3)));
         end
         tick();
      end
      n_total++;
      if (n_bad !== 0) $display("FAIL alt_items bad=%0d want=0", n_bad);
      else n_pass++;
      n_total++;
      if (n_out !== n_acc || n_acc == 0) $display("FAIL alt_count outputs=%0d want accepts=%0d", n_out, n_acc);
      else n_pass++;
      n_bad = 0;
      while (prod_q.size() > 0) begin
         e = prod_q.pop_front();
         if (e !== unmask(4, 4, isw_model(4, 4, 32'hFFFF, 32'hFFFF, 32'h0)) && 1'b0) n_bad++;
      end
      exp_q.delete();
   endtask

   task automatic test_rand_map();
      logic [23:0] c_base, c_r;
      or2 = 1;
      iv2 = 1; a2 = 24'hFFFFFF; b2 = 24'hFFFFFF; r2 = 24'h000000;
      tick();
      iv2 = 0;
      tick();
      c_base = c2;
      n_total++;
      if (ov2 !== 1'b1 || c_base !== 24'hFFFFFF) $display("FAIL map_base got v=%b c=%h want v=1 c=ffffff", ov2, c_base);
      else n_pass++;
      iv2 = 1; r2 = 24'h00FF00;
      tick();
      iv2 = 0;
      tick();
      c_r = c2;
      n_total++;
      if (ov2 !== 1'b1 || c_r !== 24'h00FF00) $display("FAIL map_word1 got v=%b c=%h want v=1 c=00ff00", ov2, c_r);
      else n_pass++;
      n_total++;
      if (c_r[15:8] !== c_base[15:8]) $display("FAIL map_c1_same got=%h want=%h", c_r[15:8], c_base[15:8]);
      else n_pass++;
      n_total++;
      if (c_r[7:0] === c_base[7:0] || c_r[23:16] === c_base[23:16])
         $display("FAIL map_c0_c2_differ got c0=%h c2=%h want both != ff", c_r[7:0], c_r[23:16]);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_exhaustive();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_alternating();
      test_rand_map();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
